// File: rtl/lcd_status_reader_if.sv
// Bus between an LCD read requester and the lcd_status_reader controller.
// The slave modport is the controller; the master modport is the requester plus LCD pins.
interface lcd_status_reader_if;
  logic       REQ;
  logic       MODE;
  logic       POLL;
  logic [7:0] LCD_DB_IN;
  logic       LCD_RS;
  logic       LCD_RW;
  logic       LCD_E;
  logic       LCD_DB_OE;
  logic       RDY;
  logic       VALID;
  logic       BUSY_FLAG;
  logic [6:0] ADDR;
  logic [7:0] RDATA;
  logic       TIMEOUT;
  logic [2:0] STATE_DBG;

  modport slave (
    input  REQ, MODE, POLL, LCD_DB_IN,
    output LCD_RS, LCD_RW, LCD_E, LCD_DB_OE, RDY, VALID,
    output BUSY_FLAG, ADDR, RDATA, TIMEOUT, STATE_DBG
  );

  modport master (
    output REQ, MODE, POLL, LCD_DB_IN,
    input  LCD_RS, LCD_RW, LCD_E, LCD_DB_OE, RDY, VALID,
    input  BUSY_FLAG, ADDR, RDATA, TIMEOUT, STATE_DBG
  );
endinterface

// File: rtl/lcd_status_reader.sv
// HD44780-style LCD read controller: single status/data reads and busy-flag polling
// with a saturating timeout. All LCD pins and results come straight from registers.
module lcd_status_reader #(
  parameter int T_AS      = 2,
  parameter int T_PW      = 12,
  parameter int T_H       = 2,
  parameter int T_GAP     = 24,
  parameter int T_TIMEOUT = 48000
) (
  input  logic                 CLK,
  input  logic                 RST,
  lcd_status_reader_if.slave   bus
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETUP  = 3'd1,
    E_HIGH = 3'd2,
    HOLD   = 3'd3,
    GAP    = 3'd4,
    DONE   = 3'd5
  } state_t;

  localparam logic [7:0]  AS_LAST  = 8'(T_AS - 1);
  localparam logic [7:0]  PW_LAST  = 8'(T_PW - 1);
  localparam logic [7:0]  H_LAST   = 8'(T_H - 1);
  localparam logic [7:0]  GAP_LAST = 8'(T_GAP - 1);
  localparam logic [22:0] TO_MAX   = 23'(T_TIMEOUT);

  state_t      state_q;
  logic [7:0]  phase_q;
  logic [22:0] to_cnt_q;
  logic [22:0] to_cnt_d;
  logic [7:0]  phase_d;
  logic        mode_q, poll_q;
  logic [7:0]  cap_q;
  logic        rs_q, rw_q, e_q, oe_q, rdy_q, valid_q;
  logic        bf_q, timeout_q;
  logic [6:0]  addr_q;
  logic [7:0]  rdata_q;

  assign to_cnt_d = (to_cnt_q < TO_MAX) ? to_cnt_q + 23'd1 : to_cnt_q;
  assign phase_d  = phase_q + 8'd1;

  // Sequencer: every output is loaded on the edge that enters the state it belongs to.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= IDLE;
      phase_q   <= 8'd0;
      to_cnt_q  <= 23'd0;
      mode_q    <= 1'b0;
      poll_q    <= 1'b0;
      cap_q     <= 8'd0;
      rs_q      <= 1'b0;
      rw_q      <= 1'b0;
      e_q       <= 1'b0;
      oe_q      <= 1'b1;
      rdy_q     <= 1'b1;
      valid_q   <= 1'b0;
      bf_q      <= 1'b0;
      addr_q    <= 7'd0;
      rdata_q   <= 8'd0;
      timeout_q <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      if (state_q != IDLE) begin
        to_cnt_q <= to_cnt_d;
      end
      case (state_q)
        IDLE: begin
          if (bus.REQ) begin
            mode_q    <= bus.MODE;
            poll_q    <= bus.POLL & ~bus.MODE;
            to_cnt_q  <= 23'd0;
            timeout_q <= 1'b0;
            phase_q   <= 8'd0;
            rdy_q     <= 1'b0;
            rw_q      <= 1'b1;
            rs_q      <= bus.MODE;
            oe_q      <= 1'b0;
            state_q   <= SETUP;
          end
        end
        SETUP: begin
          if (phase_q == AS_LAST) begin
            phase_q <= 8'd0;
            e_q     <= 1'b1;
            state_q <= E_HIGH;
          end else begin
            phase_q <= phase_d;
          end
        end
        E_HIGH: begin
          if (phase_q == PW_LAST) begin
            phase_q <= 8'd0;
            cap_q   <= bus.LCD_DB_IN;
            e_q     <= 1'b0;
            state_q <= HOLD;
          end else begin
            phase_q <= phase_d;
          end
        end
        HOLD: begin
          if (phase_q == H_LAST) begin
            phase_q <= 8'd0;
            if (poll_q && cap_q[7] && (to_cnt_q < TO_MAX)) begin
              state_q <= GAP;
            end else begin
              // Bus released and results published together with VALID.
              rw_q      <= 1'b0;
              rs_q      <= 1'b0;
              oe_q      <= 1'b1;
              valid_q   <= 1'b1;
              timeout_q <= poll_q & cap_q[7];
              if (mode_q) begin
                rdata_q <= cap_q;
              end else begin
                bf_q   <= cap_q[7];
                addr_q <= cap_q[6:0];
              end
              state_q <= DONE;
            end
          end else begin
            phase_q <= phase_d;
          end
        end
        GAP: begin
          if (phase_q == GAP_LAST) begin
            phase_q <= 8'd0;
            state_q <= SETUP;
          end else begin
            phase_q <= phase_d;
          end
        end
        DONE: begin
          rdy_q   <= 1'b1;
          state_q <= IDLE;
        end
        default: begin
          e_q     <= 1'b0;
          rw_q    <= 1'b0;
          rs_q    <= 1'b0;
          oe_q    <= 1'b1;
          rdy_q   <= 1'b1;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.LCD_RS    = rs_q;
  assign bus.LCD_RW    = rw_q;
  assign bus.LCD_E     = e_q;
  assign bus.LCD_DB_OE = oe_q;
  assign bus.RDY       = rdy_q;
  assign bus.VALID     = valid_q;
  assign bus.BUSY_FLAG = bf_q;
  assign bus.ADDR      = addr_q;
  assign bus.RDATA     = rdata_q;
  assign bus.TIMEOUT   = timeout_q;
  assign bus.STATE_DBG = state_q;

endmodule

// File: tb/tb_lcd_status_reader.sv
// Randomized + directed bench for lcd_status_reader against a transaction-level model
// (read count, VALID latency and result registers computed from the timing rules).
module tb_lcd_status_reader;
  localparam int T_TIMEOUT = 48000;

  logic CLK;
  logic RST;
  lcd_status_reader_if bus();

  lcd_status_reader dut (.CLK(CLK), .RST(RST), .bus(bus));

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] db_seq [0:15];
  int         db_len;
  logic [7:0] db_stuck;

  logic       exp_bf;
  logic [6:0] exp_addr;
  logic [7:0] exp_rdata;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] get_db(input int r);
    return (r < db_len) ? db_seq[r] : db_stuck;
  endfunction

  // One accepted transaction, observed cycle by cycle; k=1 is the cycle after the accepting edge.
  task automatic run_read(input logic m, input logic p, input string tag);
    int nr, r, exp_k, valid_k, nvalid, rises, last_rise, hi_len;
    int bad_w, bad_gap, bad_oe, bad_rs;
    logic e_prev;
    logic [7:0] last;
    logic exp_to;
    if (m || !p) nr = 1;
    else begin
      r = 0;
      // Counter during the last HOLD cycle of read r equals 15+40r.
      while (get_db(r)[7] && (15 + 40 * r < T_TIMEOUT)) r++;
      nr = r + 1;
    end
    last  = get_db(nr - 1);
    exp_k = 17 + 40 * (nr - 1);
    exp_to = !m && p && last[7];
    if (m) exp_rdata = last;
    else begin exp_bf = last[7]; exp_addr = last[6:0]; end

    @(negedge CLK);
    bus.REQ = 1'b1; bus.MODE = m; bus.POLL = p;
    @(posedge CLK); #1;
    bus.REQ = 1'b0;
    valid_k = 0; nvalid = 0; rises = 0; last_rise = 0; hi_len = 0;
    bad_w = 0; bad_gap = 0; bad_oe = 0; bad_rs = 0; e_prev = 1'b0;
    for (int k = 1; k <= exp_k + 3; k++) begin
      if (k == 1) begin
        check_eq({tag, "_state1"}, 32'(bus.STATE_DBG), 32'd1);
        check_eq({tag, "_rdy1"}, 32'(bus.RDY), 32'd0);
      end
      if (bus.LCD_E && !e_prev) begin
        rises++;
        if (rises > 1 && (k - last_rise) != 40) bad_gap++;
        last_rise = k;
        bus.LCD_DB_IN = get_db(rises - 1);
      end
      if (bus.LCD_E) hi_len++;
      if (!bus.LCD_E && e_prev) begin
        if (hi_len != 12) bad_w++;
        hi_len = 0;
      end
      if (bus.LCD_E && bus.LCD_DB_OE) bad_oe++;
      if (!bus.LCD_DB_OE && (bus.LCD_RS !== m || bus.LCD_RW !== 1'b1)) bad_rs++;
      if (bus.VALID) begin
        nvalid++;
        if (valid_k == 0) begin
          valid_k = k;
          check_eq({tag, "_bf"}, 32'(bus.BUSY_FLAG), 32'(exp_bf));
          check_eq({tag, "_addr"}, 32'(bus.ADDR), 32'(exp_addr));
          check_eq({tag, "_rdata"}, 32'(bus.RDATA), 32'(exp_rdata));
          check_eq({tag, "_timeout"}, 32'(bus.TIMEOUT), 32'(exp_to));
          check_eq({tag, "_oe_done"}, 32'(bus.LCD_DB_OE), 32'd1);
        end
      end
      e_prev = bus.LCD_E;
      // Requests while busy must be ignored.
      if (k >= 2 && k <= 14) begin
        bus.REQ = 1'($urandom_range(0, 1));
        bus.MODE = 1'($urandom_range(0, 1));
        bus.POLL = 1'($urandom_range(0, 1));
      end else bus.REQ = 1'b0;
      @(posedge CLK); #1;
    end
    check_eq({tag, "_valid_k"}, 32'(valid_k), 32'(exp_k));
    check_eq({tag, "_nvalid"}, 32'(nvalid), 32'd1);
    check_eq({tag, "_epulses"}, 32'(rises), 32'(nr));
    check_eq({tag, "_bad_width"}, 32'(bad_w), 32'd0);
    check_eq({tag, "_bad_gap"}, 32'(bad_gap), 32'd0);
    check_eq({tag, "_e_with_oe"}, 32'(bad_oe), 32'd0);
    check_eq({tag, "_rs_rw"}, 32'(bad_rs), 32'd0);
    check_eq({tag, "_rdy_end"}, 32'(bus.RDY), 32'd1);
  endtask

  initial begin
    int v1, v2, nv, rises;
    logic e_prev;
    bus.REQ = 1'b0; bus.MODE = 1'b0; bus.POLL = 1'b0; bus.LCD_DB_IN = 8'h00;
    exp_bf = 1'b0; exp_addr = 7'd0; exp_rdata = 8'd0;
    RST = 1'b1;
    repeat (3) @(posedge CLK);
    #1;
    check_eq("rst_e", 32'(bus.LCD_E), 32'd0);
    check_eq("rst_rw", 32'(bus.LCD_RW), 32'd0);
    check_eq("rst_oe", 32'(bus.LCD_DB_OE), 32'd1);
    check_eq("rst_rdy", 32'(bus.RDY), 32'd1);
    check_eq("rst_valid", 32'(bus.VALID), 32'd0);
    check_eq("rst_results", {bus.BUSY_FLAG, bus.ADDR, bus.RDATA, bus.TIMEOUT}, 32'd0);
    check_eq("rst_state", 32'(bus.STATE_DBG), 32'd0);
    @(negedge CLK); RST = 1'b0;

    db_len = 0; db_stuck = 8'h25;
    run_read(1'b0, 1'b0, "status25");
    db_stuck = 8'h61;
    run_read(1'b1, 1'b0, "data61");
    db_seq[0] = 8'h80; db_seq[1] = 8'h80; db_seq[2] = 8'h80; db_len = 3; db_stuck = 8'h00;
    run_read(1'b0, 1'b1, "poll3");

    for (int t = 0; t < 20; t++) begin
      logic m, p;
      int nb;
      m = 1'($urandom_range(0, 1));
      p = 1'($urandom_range(0, 1));
      nb = $urandom_range(0, 3);
      for (int i = 0; i < nb; i++) db_seq[i] = {1'b1, 7'($urandom)};
      db_len = nb;
      db_stuck = m ? 8'($urandom) : {1'b0, 7'($urandom)};
      run_read(m, p, $sformatf("rnd%0d", t));
    end

    // REQ held high: back-to-back reads with one IDLE cycle between them.
    db_len = 0; db_stuck = 8'h3A;
    @(negedge CLK);
    bus.REQ = 1'b1; bus.MODE = 1'b0; bus.POLL = 1'b0;
    @(posedge CLK); #1;
    v1 = 0; v2 = 0; nv = 0; rises = 0; e_prev = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      if (bus.LCD_E && !e_prev) begin rises++; bus.LCD_DB_IN = db_stuck; end
      e_prev = bus.LCD_E;
      if (bus.VALID) begin
        nv++;
        if (nv == 1) v1 = k;
        if (nv == 2) begin v2 = k; bus.REQ = 1'b0; end
      end
      @(posedge CLK); #1;
    end
    bus.REQ = 1'b0;
    check_eq("held_v1", 32'(v1), 32'd17);
    check_eq("held_v2", 32'(v2), 32'd35);
    check_eq("held_epulses", 32'(rises), 32'd2);
    check_eq("held_addr", 32'(bus.ADDR), 32'h3A);
    exp_bf = 1'b0; exp_addr = 7'h3A;

    // Reset in the middle of E high, with REQ asserted alongside.
    @(negedge CLK);
    bus.REQ = 1'b1; bus.MODE = 1'b1;
    @(posedge CLK); #1;
    bus.REQ = 1'b0;
    repeat (4) @(posedge CLK);
    #1;
    check_eq("mid_e_high", 32'(bus.LCD_E), 32'd1);
    @(negedge CLK); RST = 1'b1; bus.REQ = 1'b1;
    @(posedge CLK); #1;
    check_eq("rstmid_e", 32'(bus.LCD_E), 32'd0);
    check_eq("rstmid_rdy", 32'(bus.RDY), 32'd1);
    check_eq("rstmid_oe", 32'(bus.LCD_DB_OE), 32'd1);
    check_eq("rstmid_state", 32'(bus.STATE_DBG), 32'd0);
    @(posedge CLK); #1;
    check_eq("rst_over_req", 32'(bus.STATE_DBG), 32'd0);
    @(negedge CLK); RST = 1'b0; bus.REQ = 1'b0;
    nv = 0;
    for (int k = 0; k < 25; k++) begin
      @(posedge CLK); #1;
      if (bus.VALID) nv++;
    end
    check_eq("rstmid_novalid", 32'(nv), 32'd0);
    check_eq("rstmid_results", {bus.BUSY_FLAG, bus.ADDR, bus.RDATA}, 32'd0);
    exp_bf = 1'b0; exp_addr = 7'd0; exp_rdata = 8'd0;

    // Busy flag stuck: polling must end by timeout.
    db_len = 0; db_stuck = 8'hFF;
    run_read(1'b0, 1'b1, "timeout");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
